// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, combinational instruction memory read,
// and the IDLE/RUN/DRAIN/HALT sequencer that retires the pipeline after a halt word.
module instruction_fetch #(
  parameter int unsigned IMEM_DEPTH   = 256,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data,
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        halted,
  output logic [1:0]  state_out
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0]   mem [IMEM_DEPTH];
  logic [AW-1:0] fetch_idx;
  logic          fetch_oob;
  logic [31:0]   fetch_word;
  logic [AW-1:0] prog_idx;
  logic          prog_oob;
  logic          unused_prog_lsb;

  // Word-indexed fetch; addresses beyond the memory read as zero but stay valid.
  assign fetch_idx  = pc_q[AW+1:2];
  assign fetch_oob  = |pc_q[31:AW+2];
  assign fetch_word = fetch_oob ? 32'h0 : mem[fetch_idx];

  assign prog_idx        = prog_addr[AW+1:2];
  assign prog_oob        = |prog_addr[31:AW+2];
  assign unused_prog_lsb = ^prog_addr[1:0];

  // Program load is only accepted while idle; contents survive reset.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == IDLE) && !prog_oob) begin
      mem[prog_idx] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (enable) begin
      unique case (state_q)
        IDLE: begin
          if (start) state_d = RUN;
        end
        RUN: begin
          if (redirect_valid) begin
            pc_d = redirect_pc;
          end else if (!stall) begin
            if (fetch_word == HALT_INSTR) begin
              state_d = DRAIN;
              cnt_d   = CW'(DRAIN_CYCLES);
            end else begin
              pc_d = pc_q + 32'd4;
            end
          end
        end
        DRAIN: begin
          // A redirect means the halt sat on a squashed path; resume fetching.
          if (redirect_valid) begin
            pc_d    = redirect_pc;
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q <= CW'(1)) state_d = HALT;
          end
        end
        HALT: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign instr_valid = (state_q == RUN);
  assign instr_out   = instr_valid ? fetch_word : 32'h0;
  assign halted      = (state_q == HALT);
  assign state_out   = state_q;
  assign pc_out      = pc_q;
  assign next_pc_out = pc_q + 32'd4;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: program load, fetch, stall/redirect,
// drain/halt, enable freeze and reset behaviour against hand-computed values.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        start;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic [31:0] pc_out;
  logic [31:0] next_pc_out;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        halted;
  logic [1:0]  state_out;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

  instruction_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .start          (start),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .prog_we        (prog_we),
    .prog_addr      (prog_addr),
    .prog_data      (prog_data),
    .pc_out         (pc_out),
    .next_pc_out    (next_pc_out),
    .instr_out      (instr_out),
    .instr_valid    (instr_valid),
    .halted         (halted),
    .state_out      (state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] a);
    redirect_valid = 1'b1; redirect_pc = a;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; start = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    tick(); tick();
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_npc", next_pc_out, 32'h4);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);
    reset = 1'b1;

    prog(32'h0, 32'h2001_0005);
    prog(32'h4, 32'h2002_0003);
    prog(32'h8, HALTW);
    prog(32'h10, 32'hAAAA_0004);
    prog(32'h20, 32'h2222_0020);
    prog(32'h40, 32'h0BAD_0040);
    prog(32'h400, 32'hDEAD_BEEF);   // out of range, would alias word 0

    // basic program run to halt
    pulse_start();
    chk("run_state", 32'(state_out), 32'd1);
    chk("run_pc0", pc_out, 32'h0);
    chk("run_i0", instr_out, 32'h2001_0005);
    chk("run_v0", 32'(instr_valid), 32'd1);
    tick();
    chk("run_pc4", pc_out, 32'h4);
    chk("run_i4", instr_out, 32'h2002_0003);
    tick();
    chk("run_pc8", pc_out, 32'h8);
    chk("run_i8", instr_out, HALTW);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("drain_state%0d", i), 32'(state_out), 32'd2);
      chk($sformatf("drain_pc%0d", i), pc_out, 32'h8);
      chk($sformatf("drain_instr%0d", i), instr_out, 32'h0);
      chk($sformatf("drain_valid%0d", i), 32'(instr_valid), 32'd0);
    end
    tick();
    chk("halt_state", 32'(state_out), 32'd3);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc", pc_out, 32'h8);
    pulse_start();
    tick();
    chk("halt_start_ign", 32'(state_out), 32'd3);
    redirect(32'h40);
    chk("halt_redir_ign", pc_out, 32'h8);

    // stall, write in RUN ignored, redirect during stall
    do_reset();
    chk("rst2_state", 32'(state_out), 32'd0);
    chk("rst2_pc", pc_out, 32'h0);
    pulse_start();
    redirect(32'h10);
    chk("st_pc", pc_out, 32'h10);
    chk("st_instr", instr_out, 32'hAAAA_0004);
    stall = 1'b1;
    prog_we = 1'b1; prog_addr = 32'h10; prog_data = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_pc%0d", i), pc_out, 32'h10);
      chk($sformatf("stall_instr%0d", i), instr_out, 32'hAAAA_0004);
    end
    prog_we = 1'b0;
    redirect(32'h40);
    stall = 1'b0;
    chk("st_redir_pc", pc_out, 32'h40);
    chk("st_redir_instr", instr_out, 32'h0BAD_0040);
    tick();
    chk("inc_pc", pc_out, 32'h44);
    chk("inc_npc", next_pc_out, 32'h48);

    // out-of-range fetch and 32-bit wrap
    redirect(32'h400);
    chk("oob_instr", instr_out, 32'h0);
    chk("oob_valid", 32'(instr_valid), 32'd1);
    redirect(32'hFFFF_FFFC);
    chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
    chk("wrap_npc", next_pc_out, 32'h0);
    tick();
    chk("wrap_pc0", pc_out, 32'h0);
    chk("wrap_i0", instr_out, 32'h2001_0005);

    // halt on squashed path: redirect on 2nd drain cycle
    redirect(32'h8);
    tick();
    chk("sq_drain1", 32'(state_out), 32'd2);
    tick();
    chk("sq_drain2", 32'(state_out), 32'd2);
    redirect(32'h20);
    chk("sq_state", 32'(state_out), 32'd1);
    chk("sq_pc", pc_out, 32'h20);
    chk("sq_instr", instr_out, 32'h2222_0020);
    chk("sq_halted", 32'(halted), 32'd0);

    // enable freeze in RUN
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("frz_run_pc%0d", i), pc_out, 32'h20);
      chk($sformatf("frz_run_st%0d", i), 32'(state_out), 32'd1);
    end
    enable = 1'b1;
    redirect(32'h8);
    chk("frz_resume_pc", pc_out, 32'h8);
    tick();
    tick();
    chk("frz_drain_in", 32'(state_out), 32'd2);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("frz_drain_st%0d", i), 32'(state_out), 32'd2);
      chk($sformatf("frz_drain_pc%0d", i), pc_out, 32'h8);
    end
    enable = 1'b1;
    tick();
    chk("frz_d_a", 32'(state_out), 32'd2);
    tick();
    chk("frz_d_b", 32'(state_out), 32'd2);
    tick();
    chk("frz_d_halt", 32'(state_out), 32'd3);

    // reset mid-drain, memory preserved
    do_reset();
    pulse_start();
    redirect(32'h8);
    tick();
    tick();
    chk("mid_drain", 32'(state_out), 32'd2);
    do_reset();
    chk("mrst_state", 32'(state_out), 32'd0);
    chk("mrst_pc", pc_out, 32'h0);
    chk("mrst_npc", next_pc_out, 32'h4);
    chk("mrst_valid", 32'(instr_valid), 32'd0);
    chk("mrst_halted", 32'(halted), 32'd0);
    pulse_start();
    chk("mem_keep0", instr_out, 32'h2001_0005);
    tick();
    chk("mem_keep4", instr_out, 32'h2002_0003);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter IMEM_DEPTH, default 256, instruction memory size in 32-bit words (power of two).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, PC value after reset.
REQ-003 Parameter DRAIN_CYCLES, default 4, cycles spent in DRAIN before HALT (range 1-7).
REQ-004 Parameter HALT_INSTR, default 32'hFFFF_FFFF, encoding of the halt instruction.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-007 enable  input  1  debug run/step gate; 0 freezes the stage like stall.
REQ-008 start  input  1  pulse; leaves IDLE and begins fetching.
REQ-009 stall  input  1  hazard-unit hold; PC and outputs keep their values.
REQ-010 redirect_valid  input  1  branch/jump taken or misprediction correction.
REQ-011 redirect_pc  input  32  byte address of the redirect target.
REQ-012 prog_we  input  1  instruction memory write strobe (program load).
REQ-013 prog_addr  input  32  byte address of the program word; bits [1:0] ignored.
REQ-014 prog_data  input  32  program word.
REQ-015 pc_out  output  32  address of the instruction on instr_out.
REQ-016 next_pc_out  output  32  pc_out + 4, feeds the IF/ID next_pc field.
REQ-017 instr_out  output  32  fetched instruction, or 32'h0 (NOP) when not valid.
REQ-018 instr_valid  output  1  instr_out is a real fetched instruction.
REQ-019 halted  output  1  high only in state HALT.
REQ-020 state_out  output  2  IDLE=0, RUN=1, DRAIN=2, HALT=3.

Function
REQ-021 PC SHALL be a 32-bit register; instruction memory SHALL be read combinationally at word index pc[log2(IMEM_DEPTH)+1:2].
REQ-022 A PC with word index >= IMEM_DEPTH SHALL yield instr_out = 32'h0 while instr_valid stays 1.
REQ-023 IDLE: PC held, instr_out = 0, instr_valid = 0; prog_we writes prog_data at prog_addr word index; start=1 -> RUN next cycle.
REQ-024 prog_we outside IDLE, or a write to an out-of-range word index, SHALL be ignored.
REQ-025 RUN: instr_valid = 1, instr_out = mem[pc]; an active cycle is one with enable=1.
REQ-026 RUN, active cycle, redirect_valid=1 -> PC <= redirect_pc, regardless of stall.
REQ-027 RUN, active cycle, stall=1, no redirect -> PC held.
REQ-028 RUN, active cycle, no stall, no redirect -> PC <= PC + 4, with 32-bit wrap-around.
REQ-029 RUN, active cycle, no stall, no redirect, instr_out == HALT_INSTR -> PC held, state DRAIN, drain counter <= DRAIN_CYCLES; the halt word is presented exactly once.
REQ-030 DRAIN: instr_out = 0, instr_valid = 0; the counter decrements on every active cycle; stall SHALL NOT affect DRAIN.
REQ-031 DRAIN, active cycle, redirect_valid=1 (halt was on a squashed path) -> PC <= redirect_pc, state RUN; this takes priority over the counter.
REQ-032 DRAIN, counter reaching 0 with no redirect -> HALT.
REQ-033 HALT: PC held, instr_out = 0, instr_valid = 0, halted = 1; all inputs ignored; only reset exits.
REQ-034 enable=0 in any state SHALL freeze PC, state and counter; outputs keep their values.
REQ-035 start SHALL be ignored outside IDLE.

Reset
REQ-036 reset=0 at a clock edge -> PC = RESET_PC, state IDLE, counter = 0, instr_valid = 0, halted = 0, instr_out = 0, next_pc_out = RESET_PC + 4, from any state including mid-DRAIN.
REQ-037 Reset SHALL NOT clear instruction memory contents.

Verification
REQ-038 Load words 0x20010005, 0x20020003, 0xFFFFFFFF at 0x0/0x4/0x8, then start -> pc_out 0,4,8 on consecutive cycles; DRAIN 4 cycles; then halted=1 with pc_out=8.
REQ-039 RUN at pc=0x10 with stall=1 for 3 cycles -> pc_out stays 0x10 with the same instr_out; redirect_valid=1, redirect_pc=0x40 during stall -> next pc_out=0x40.
REQ-040 HALT fetched at 0x8, redirect to 0x20 on the 2nd DRAIN cycle -> state RUN, pc_out=0x20, halted never asserted.
REQ-041 prog_we=1 to 0x0 in RUN -> memory unchanged; after reset the program still runs and fetches its original words.
REQ-042 enable=0 for 5 cycles in RUN and in DRAIN -> PC, state and counter frozen; the sequence resumes unchanged when enable=1.
REQ-043 reset=0 mid-DRAIN -> next cycle state IDLE, pc_out=RESET_PC, instr_valid=0; a start pulse while in HALT is ignored.
